// File: rtl/main_unit.sv
// Pulse extender: holds extended_pulse high while original_pulse is high, then EXT_LEN more cycles.
// Optional macro SYNC_IN_EN adds a 2-flop input synchronizer (two extra cycles of latency).
module main_unit #(
    parameter int unsigned EXT_LEN = 10,
    parameter int unsigned CNT_W   = $clog2(EXT_LEN + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic original_pulse,
    output logic extended_pulse,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        STRETCH = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pulse_s;

`ifdef SYNC_IN_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer; cleared by reset so no stale pulse survives it
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], original_pulse};
        end
    end

    assign pulse_s = sync_q[1];
`else
    assign pulse_s = original_pulse;
`endif

    // Stretch FSM; counter is loaded on the fall and only counts down while nonzero
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            extended_pulse <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pulse_s) begin
                        state          <= HOLD;
                        extended_pulse <= 1'b1;
                    end else begin
                        extended_pulse <= 1'b0;
                    end
                    busy <= 1'b0;
                end
                HOLD: begin
                    extended_pulse <= 1'b1;
                    if (pulse_s) begin
                        busy <= 1'b0;
                    end else begin
                        state <= STRETCH;
                        cnt   <= CNT_W'(EXT_LEN - 1);
                        busy  <= 1'b1;
                    end
                end
                STRETCH: begin
                    if (pulse_s) begin
                        state          <= HOLD;
                        extended_pulse <= 1'b1;
                        busy           <= 1'b0;
                    end else if (cnt == '0) begin
                        state          <= IDLE;
                        extended_pulse <= 1'b0;
                        busy           <= 1'b0;
                    end else begin
                        cnt            <= cnt - CNT_W'(1);
                        extended_pulse <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    cnt            <= '0;
                    extended_pulse <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_unit.sv
// Directed bench for main_unit (EXT_LEN=10); honours SYNC_IN_EN via an extra latency offset.
module tb_main_unit;

    localparam int unsigned EXT = 10;
`ifdef SYNC_IN_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst;
    logic original_pulse;
    logic extended_pulse;
    logic busy;

    int total;
    int bad;

    main_unit #(.EXT_LEN(EXT)) dut (
        .clk            (clk),
        .rst            (rst),
        .original_pulse (original_pulse),
        .extended_pulse (extended_pulse),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs just after an edge, advance one edge, settle for sampling
    task automatic tick(input logic p, input logic r);
        original_pulse = p;
        rst            = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic exp_e;
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        total++;
        if (extended_pulse !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_priority: ext=%b busy=%b want ext=0 busy=0", extended_pulse, busy);
        end
        // Release reset with input already high: rise at the first non-reset edge
        for (int k = 1; k <= 3 + LAT; k++) begin
            tick(1'b1, 1'b0);
            exp_e = (k >= 1 + LAT);
            total++;
            if (extended_pulse !== exp_e) begin
                bad++;
                $display("FAIL reset_release k=%0d: ext=%b want %b", k, extended_pulse, exp_e);
            end
        end
        tick(1'b1, 1'b1);
        total++;
        if (extended_pulse !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_hold: ext=%b busy=%b want ext=0 busy=0", extended_pulse, busy);
        end
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b0);
    endtask

    task automatic test_basic();
        logic exp_e, exp_b;
        int width;
        width = 0;
        for (int k = 1; k <= 2 + 10 + LAT + 3; k++) begin
            tick(k <= 2, 1'b0);
            exp_e = (k >= 1 + LAT) && (k <= 12 + LAT);
            exp_b = (k >= 3 + LAT) && (k <= 12 + LAT);
            if (extended_pulse === 1'b1) width++;
            total++;
            if (extended_pulse !== exp_e || busy !== exp_b) begin
                bad++;
                $display("FAIL basic k=%0d: ext=%b busy=%b want ext=%b busy=%b",
                         k, extended_pulse, busy, exp_e, exp_b);
            end
        end
        total++;
        if (width != 12) begin
            bad++;
            $display("FAIL basic_width: got %0d want 12", width);
        end
    endtask

    task automatic test_single();
        logic exp_e;
        int width;
        width = 0;
        for (int k = 1; k <= 11 + LAT + 3; k++) begin
            tick(k == 1, 1'b0);
            exp_e = (k >= 1 + LAT) && (k <= 11 + LAT);
            if (extended_pulse === 1'b1) width++;
            total++;
            if (extended_pulse !== exp_e) begin
                bad++;
                $display("FAIL single k=%0d: ext=%b want %b", k, extended_pulse, exp_e);
            end
        end
        total++;
        if (width != 11) begin
            bad++;
            $display("FAIL single_width: got %0d want 11", width);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_e, exp_b;
        for (int k = 1; k <= 18 + LAT + 3; k++) begin
            tick((k <= 2) || (k == 8), 1'b0);
            exp_e = (k >= 1 + LAT) && (k <= 18 + LAT);
            exp_b = ((k >= 3 + LAT) && (k <= 7 + LAT)) || ((k >= 9 + LAT) && (k <= 18 + LAT));
            total++;
            if (extended_pulse !== exp_e || busy !== exp_b) begin
                bad++;
                $display("FAIL retrigger k=%0d: ext=%b busy=%b want ext=%b busy=%b",
                         k, extended_pulse, busy, exp_e, exp_b);
            end
        end
    endtask

    task automatic test_reset_mid_stretch();
        logic exp_e, exp_b;
        for (int k = 1; k <= 6; k++) begin
            tick(k <= 2, 1'b0);
            exp_e = (k >= 1 + LAT);
            exp_b = (k >= 3 + LAT);
            total++;
            if (extended_pulse !== exp_e || busy !== exp_b) begin
                bad++;
                $display("FAIL pre_reset k=%0d: ext=%b busy=%b want ext=%b busy=%b",
                         k, extended_pulse, busy, exp_e, exp_b);
            end
        end
        tick(1'b0, 1'b1);
        for (int k = 0; k <= 14; k++) begin
            total++;
            if (extended_pulse !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL post_reset k=%0d: ext=%b busy=%b want ext=0 busy=0", k, extended_pulse, busy);
            end
            tick(1'b0, 1'b0);
        end
    endtask

    task automatic test_long_hold();
        logic exp_e;
        int width;
        width = 0;
        for (int k = 1; k <= 40 + LAT + 6; k++) begin
            tick(k <= 30, 1'b0);
            exp_e = (k >= 1 + LAT) && (k <= 40 + LAT);
            if (extended_pulse === 1'b1) width++;
            total++;
            if (extended_pulse !== exp_e) begin
                bad++;
                $display("FAIL long_hold k=%0d: ext=%b want %b", k, extended_pulse, exp_e);
            end
        end
        total++;
        if (width != 40) begin
            bad++;
            $display("FAIL long_hold_width: got %0d want 40", width);
        end
    endtask

    task automatic test_glitch();
        // High only between edges: never sampled, so no output
        original_pulse = 1'b0;
        #1 original_pulse = 1'b1;
        #2 original_pulse = 1'b0;
        for (int k = 1; k <= 4 + LAT; k++) begin
            tick(1'b0, 1'b0);
            total++;
            if (extended_pulse !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL glitch k=%0d: ext=%b busy=%b want ext=0 busy=0", k, extended_pulse, busy);
            end
        end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst            = 1'b1;
        original_pulse = 1'b0;
        test_reset();
        test_basic();
        test_single();
        test_back_to_back();
        test_reset_mid_stretch();
        test_long_hold();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main_unit.md
Name: main_unit

Overview:
- Pulse extender (stretcher). It widens a short input pulse into a longer output pulse in a single clock domain.
- The output goes high with the input and stays high while the input is high. After the input falls, the output stays high for EXT_LEN more clock cycles.
- Used to make narrow strobes visible to slower logic, for example a clk/5 consumer, without a second clock.

Parameters:
- EXT_LEN, default 10: number of clk cycles the output is held after the input is sampled low. Legal range 1 to 65535. The default equals two clk/5 periods.
- CNT_W, default $clog2(EXT_LEN+1): width of the stretch counter. Derived; do not override.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- original_pulse, input, 1: pulse to extend. Treated as synchronous to clk unless SYNC_IN_EN is defined.
- extended_pulse, output, 1: stretched pulse, registered.
- busy, output, 1: high while in the STRETCH state, i.e. input already low and counter not yet expired.

Behaviour:
- Reset: rst sampled high sets extended_pulse=0, busy=0, counter=0, state=IDLE. Reset has priority over all other inputs.
- State IDLE:
  - Input sampled 1: go to HOLD and set extended_pulse=1 at that same edge.
  - Input sampled 0: stay in IDLE, extended_pulse=0.
- State HOLD:
  - Input sampled 1: stay in HOLD, extended_pulse=1.
  - Input sampled 0: go to STRETCH, load counter=EXT_LEN-1, extended_pulse stays 1, busy=1.
- State STRETCH:
  - Input sampled 1 (retrigger): go to HOLD, extended_pulse stays 1, busy=0. The counter is reloaded on the next fall.
  - Else if counter==0: go to IDLE, extended_pulse=0, busy=0.
  - Else: decrement counter, output stays 1.
- Net timing: input sampled high for N consecutive edges (N>=1) gives extended_pulse high for exactly N+EXT_LEN consecutive cycles. The rise has latency 1 edge after the input is set before an edge.
- Retrigger inside STRETCH merges into one continuous output pulse. The output never drops for a single cycle between triggers.
- Input never sampled high (glitch shorter than one clk period between edges): no output.
- Input held high indefinitely: output held high indefinitely; no timeout.
- Reset asserted mid-HOLD or mid-STRETCH: output is 0 at the next edge. Counter and state are cleared; nothing resumes after reset is released.
- Input high while rst is released: output rises at the first edge with rst=0 and input=1.
- Counter never wraps:
  - Decrements only in STRETCH while the counter is nonzero.
  - Is loaded only on the HOLD to STRETCH transition.
  - Width CNT_W holds EXT_LEN-1.

Optional Feature:
- Macro: SYNC_IN_EN.
- Defined: original_pulse passes through a 2-flop synchronizer, cleared to 0 by rst, before the state machine.
  - All output edges are delayed by 2 extra cycles.
  - Output width is unchanged (N+EXT_LEN).
  - The input may be asynchronous.
- Not defined: original_pulse feeds the state machine directly; latency as specified above.

Test Plan:
- Reset, then input high for 2 cycles starting at cycle 3 (EXT_LEN=10) -> extended_pulse rises at the first sampling edge and stays high for exactly 12 cycles. busy is high for the last 10 cycles, then both are 0.
- Input high 1 cycle -> output high exactly 11 cycles.
- Retrigger: 2-cycle pulse, then a second 1-cycle pulse 5 cycles after the first fall -> one continuous output pulse of 2+5+1+10=18 cycles. busy drops during the retrigger cycle.
- Reset mid-stretch: rst asserted 4 cycles into STRETCH -> extended_pulse=0 and busy=0 at the next edge and stay 0 after rst is released with input low.
- Input held high 30 cycles -> output high 40 cycles. Idle input afterwards -> output stays 0.
- With SYNC_IN_EN: first scenario repeated -> same 12-cycle width, rise delayed by 2 cycles.
